alu_share_ctrl: RTL

Sequential front-end that shares the single combinational 7-bit ALU (add / subtract / compare / multiply) between two requesters. It arbitrates round-robin and drives the ALU operand and opcode inputs from registers. After a programmable settle window it captures the 14-bit ALU result. It returns the result to the winning requester over a four-phase req/ack handshake. It sits between the board-level input logic (switch/command sources) and the ALU instance; the ALU's anode/segment comparator outputs bypass this block.

---
 rtl/alu_share_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
//
// This block lets two requesters share one combinational 7-bit ALU
// (add / sub / compare / multiply). It picks a requester round-robin and
// drives that requester's operands and opcode to the ALU from registers.
// It waits SETTLE_CYCLES clocks, captures the 14-bit ALU result, and then
// returns the result over a four-phase req/ack handshake.
//
// Parameters
//   SETTLE_CYCLES  clocks the operands are held on the ALU before capture
//                  (legal range 1..15)
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   req0/a0/b0/op0 requester 0 request level, operands and opcode
//   ack0           requester 0 acknowledge (result valid while high)
//   req1/a1/b1/op1 requester 1 request level, operands and opcode
//   ack1           requester 1 acknowledge
//   alu_a/alu_b    registered operands to the ALU
//   alu_op         registered opcode to the ALU
//   alu_result     ALU result bus
//   result         captured result, held until the next capture
//   result_id      requester that owns result
//   result_valid   one-cycle pulse on the capture edge
//   busy           high while an operation is settling or waiting for ack
// ---------------------------------------------------------------------------
module alu_share_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic [6:0]  a0,
   input  logic [6:0]  b0,
   input  logic [1:0]  op0,
   output logic        ack0,
   input  logic        req1,
   input  logic [6:0]  a1,
   input  logic [6:0]  b1,
   input  logic [1:0]  op1,
   output logic        ack1,
   output logic [6:0]  alu_a,
   output logic [6:0]  alu_b,
   output logic [1:0]  alu_op,
   input  logic [13:0] alu_result,
   output logic [13:0] result,
   output logic        result_id,
   output logic        result_valid,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // The counter reloads with N-1 so that the capture lands exactly
   // SETTLE_CYCLES edges after the grant edge.
   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        last_reg, last_next;
   logic        grant_reg, grant_next;
   logic [6:0]  alu_a_reg, alu_a_next;
   logic [6:0]  alu_b_reg, alu_b_next;
   logic [1:0]  alu_op_reg, alu_op_next;
   logic [13:0] result_reg, result_next;
   logic        result_id_reg, result_id_next;
   logic        result_valid_reg, result_valid_next;
   logic [1:0]  ack_reg, ack_next;

   // If both requesters are asking, the one that was not served last wins.
   // If only one is asking, that one wins.
   logic pick_id;
   logic granted_req;

   assign pick_id     = (req0 && req1) ? ~last_reg : req1;
   assign granted_req = grant_reg ? req1 : req0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= IDLE;
         cnt_reg          <= 4'd0;
         last_reg         <= 1'b1;
         grant_reg        <= 1'b0;
         alu_a_reg        <= 7'd0;
         alu_b_reg        <= 7'd0;
         alu_op_reg       <= 2'd0;
         result_reg       <= 14'd0;
         result_id_reg    <= 1'b0;
         result_valid_reg <= 1'b0;
         ack_reg          <= 2'b00;
      end else begin
         state_reg        <= state_next;
         cnt_reg          <= cnt_next;
         last_reg         <= last_next;
         grant_reg        <= grant_next;
         alu_a_reg        <= alu_a_next;
         alu_b_reg        <= alu_b_next;
         alu_op_reg       <= alu_op_next;
         result_reg       <= result_next;
         result_id_reg    <= result_id_next;
         result_valid_reg <= result_valid_next;
         ack_reg          <= ack_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      cnt_next          = cnt_reg;
      last_next         = last_reg;
      grant_next        = grant_reg;
      alu_a_next        = alu_a_reg;
      alu_b_next        = alu_b_reg;
      alu_op_next       = alu_op_reg;
      result_next       = result_reg;
      result_id_next    = result_id_reg;
      result_valid_next = 1'b0;
      ack_next          = ack_reg;

      case (state_reg)
         IDLE: begin
            if (req0 || req1) begin
               grant_next = pick_id;
               last_next  = pick_id;
               cnt_next   = SETTLE_INIT;
               state_next = SETTLE;
               if (pick_id) begin
                  alu_a_next  = a1;
                  alu_b_next  = b1;
                  alu_op_next = op1;
               end else begin
                  alu_a_next  = a0;
                  alu_b_next  = b0;
                  alu_op_next = op0;
               end
            end
         end

         SETTLE: begin
            // Requester inputs are deliberately ignored here. The ALU sees
            // only the registered operands.
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               result_next          = alu_result;
               result_id_next       = grant_reg;
               result_valid_next    = 1'b1;
               ack_next[grant_reg]  = 1'b1;
               state_next           = DONE;
            end
         end

         DONE: begin
            // The ack follows the granted req down. A req that was dropped
            // early is released at the first DONE edge.
            if (!granted_req) begin
               ack_next   = 2'b00;
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
            ack_next   = 2'b00;
         end
      endcase
   end

   assign ack0         = ack_reg[0];
   assign ack1         = ack_reg[1];
   assign alu_a        = alu_a_reg;
   assign alu_b        = alu_b_reg;
   assign alu_op       = alu_op_reg;
   assign result       = result_reg;
   assign result_id    = result_id_reg;
   assign result_valid = result_valid_reg;
   assign busy         = (state_reg != IDLE);

endmodule
